// File: rtl/boot_button_qualifier.sv
// Front-panel button qualifier: synchronise, debounce and time the active-low button,
// producing a sticky boot request on release of a long press. Optional: BOOT_QUAL_CANCEL_EN.
module boot_button_qualifier #(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned HOLD_CYCLES     = 250000000,
    parameter int unsigned CANCEL_CYCLES   = 1250000000
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic PANO_BUTTON,
    input  logic boot_enable,
    output logic pressed,
    output logic short_press,
    output logic armed,
    output logic boot
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(CANCEL_CYCLES + 1);

    localparam logic [DW-1:0] DB_LIMIT   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_MAX   = '1;
`ifdef BOOT_QUAL_CANCEL_EN
    localparam logic [HW-1:0] CANCEL_LIMIT = HW'(CANCEL_CYCLES);
`endif

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HOLD     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_FIRE     = 3'd3;
`ifdef BOOT_QUAL_CANCEL_EN
    localparam logic [2:0] ST_CANCELED = 3'd4;
`endif

    logic          sync1_q, sync2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          pressed_q, pressed_d;
    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic          short_press_q, short_press_d;
    logic          armed_q, boot_q;
    logic          btn_sample;

    // Synchroniser output, converted to 1 = pressed.
    assign btn_sample = ~sync2_q;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        db_cnt_d  = '0;
        pressed_d = pressed_q;
        if (btn_sample != pressed_q) begin
            if (db_cnt_q == DB_LIMIT) begin
                pressed_d = ~pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    assign hcnt_inc = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HW'(1);

    // Release is checked before any threshold so it wins when both happen in one cycle.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        short_press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_q) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                end
            end
            ST_HOLD: begin
                hcnt_d = hcnt_inc;
                if (!pressed_q) begin
                    short_press_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (hcnt_inc >= HOLD_LIMIT) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
`ifdef BOOT_QUAL_CANCEL_EN
                hcnt_d = hcnt_inc;
                if (!pressed_q) begin
                    state_d = boot_enable ? ST_FIRE : ST_IDLE;
                end else if (hcnt_inc >= CANCEL_LIMIT) begin
                    state_d = ST_CANCELED;
                end
`else
                if (!pressed_q) begin
                    state_d = boot_enable ? ST_FIRE : ST_IDLE;
                end
`endif
            end
            ST_FIRE: begin
                state_d = ST_FIRE;
            end
`ifdef BOOT_QUAL_CANCEL_EN
            ST_CANCELED: begin
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            db_cnt_q      <= '0;
            pressed_q     <= 1'b0;
            state_q       <= ST_IDLE;
            hcnt_q        <= '0;
            short_press_q <= 1'b0;
            armed_q       <= 1'b0;
            boot_q        <= 1'b0;
        end else begin
            sync1_q       <= PANO_BUTTON;
            sync2_q       <= sync1_q;
            db_cnt_q      <= db_cnt_d;
            pressed_q     <= pressed_d;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            short_press_q <= short_press_d;
            armed_q       <= (state_d == ST_ARMED);
            boot_q        <= (state_d == ST_FIRE);
        end
    end

    assign pressed     = pressed_q;
    assign short_press = short_press_q;
    assign armed       = armed_q;
    assign boot        = boot_q;

endmodule
